v2f_mem_access_unit: RTL

//  Load/store front-end directly upstream of the v2f programmable RAM. Accepts byte/half/word

---
 rtl/v2f_mem_access_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/v2f_mem_access_unit.sv
// v2f memory access unit: byte/half/word load-store front-end for the v2f programmable RAM.
// One request in flight at a time; RAM strobes are registered and live only during ACCESS.
module v2f_mem_access_unit #(
  parameter int ABITS  = 2,
  parameter int OFFSET = 0
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [1:0]       REQ_SIZE,
  input  logic             REQ_SIGNED,
  input  logic [31:0]      REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_RDATA,
  output logic             RSP_ERR,
  output logic             RAM_RD_EN,
  output logic [ABITS-1:0] RAM_RD_ADDR,
  input  logic [31:0]      RAM_RD_DATA,
  output logic [31:0]      RAM_WR_EN,
  output logic [ABITS-1:0] RAM_WR_ADDR,
  output logic [31:0]      RAM_WR_DATA,
  output logic [3:0]       RAM_BYTE_SELECT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]  state;
  logic        accept;
  logic        req_err;
  logic [30:0] word_diff;
  logic        we_p0;
  logic [1:0]  size_p0;
  logic        signed_p0;
  logic [1:0]  lo_p0;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_mask = 4'b0001 << lo;
      2'b01:   lane_mask = 4'b0011 << lo;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] align_load(input logic [31:0] d, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] lo);
    logic [31:0] s;
    s = d >> {lo, 3'b000};
    case (size)
      2'b00:   align_load = {{24{sgn & s[7]}}, s[7:0]};
      2'b01:   align_load = {{16{sgn & s[15]}}, s[15:0]};
      default: align_load = s;
    endcase
  endfunction

  assign REQ_READY = (state == S_IDLE);
  assign RSP_VALID = (state == S_RESP);
  assign accept    = REQ_VALID & REQ_READY;

  // Bit 30 of the difference flags an address below the RAM base.
  assign word_diff = {1'b0, REQ_ADDR[31:2]} - 31'(OFFSET);

  always_comb begin
    req_err = 1'b0;
    if (REQ_SIZE == 2'b11)                          req_err = 1'b1;
    if (REQ_SIZE == 2'b01 && REQ_ADDR[0])           req_err = 1'b1;
    if (REQ_SIZE == 2'b10 && REQ_ADDR[1:0] != 2'b00) req_err = 1'b1;
    if (word_diff[30])                              req_err = 1'b1;
    if ((word_diff[29:0] >> ABITS) != 30'd0)        req_err = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      we_p0     <= REQ_WE;
      size_p0   <= REQ_SIZE;
      signed_p0 <= REQ_SIGNED;
      lo_p0     <= REQ_ADDR[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state           <= S_IDLE;
      RSP_RDATA       <= '0;
      RSP_ERR         <= 1'b0;
      RAM_RD_EN       <= 1'b0;
      RAM_RD_ADDR     <= '0;
      RAM_WR_EN       <= '0;
      RAM_WR_ADDR     <= '0;
      RAM_WR_DATA     <= '0;
      RAM_BYTE_SELECT <= '0;
    end else begin
      RAM_RD_EN       <= 1'b0;
      RAM_WR_EN       <= '0;
      RAM_BYTE_SELECT <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            RSP_RDATA <= '0;
            RSP_ERR   <= req_err;
            if (req_err) begin
              state <= S_RESP;
            end else begin
              // Strobes launched here are what the RAM sees during ACCESS.
              state       <= S_ACCESS;
              RAM_RD_ADDR <= word_diff[ABITS-1:0];
              RAM_WR_ADDR <= word_diff[ABITS-1:0];
              if (REQ_WE) begin
                RAM_WR_EN       <= '1;
                RAM_BYTE_SELECT <= lane_mask(REQ_SIZE, REQ_ADDR[1:0]);
                RAM_WR_DATA     <= lane_data(REQ_SIZE, REQ_WDATA);
              end else begin
                RAM_RD_EN <= 1'b1;
              end
            end
          end
        end
        S_ACCESS: state <= we_p0 ? S_RESP : S_CAPTURE;
        // Registered RAM data is valid here, one cycle after the read strobe.
        S_CAPTURE: begin
          RSP_RDATA <= align_load(RAM_RD_DATA, size_p0, signed_p0, lo_p0);
          state     <= S_RESP;
        end
        default: if (RSP_READY) state <= S_IDLE;
      endcase
    end
  end

endmodule
